stage_memory: RTL and testbench
===============================

# stage_memory

Memory (MEM) stage of the 16-bit single-issue pipeline, between execute and write-back. It owns the data memory, performing word loads/stores at the ALU-computed address. It resolves set-on-condition instructions (SEQ/SLT/SLE/SCO) from ALU flags. It forwards write-back control (RegWrite, MemToReg, WriteReg) unchanged.

## Interface
- ADDR_W, 8: word-address width; memory holds 2^ADDR_W 16-bit words.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Asynchronous, active-low.
- ALUResultIn  in  16  ALU result; also the byte address for loads and stores.
- ReadData2  in  16  store data.
- ALUFlags  in  3  flags: [0]=Z (zero), [1]=N (less-than), [2]=C (carry-out).
- SetSelect  in  3  [2]=set-instruction, [1:0]=condition.
- DMemEn  in  1  memory access enable.
- DMemWrite  in  1  1=store, 0=load (only when DMemEn=1).
- DMemDump  in  1  request memory dump (see Configuration).
- WriteRegIn / WriteRegOut  in / out  3  destination register, pass-through.
- RegWriteIn / RegWriteOut  in / out  1  pass-through.
- MemToRegIn / MemToRegOut  in / out  1  pass-through.
- ALUResultOut  out  16  ALU result or set value.
- DMemOutData  out  16  load data.

## Operation
- Pass-through outputs are combinational copies of their inputs, independent of rst.
- ALUResultOut:
  - If SetSelect[2]=0, ALUResultOut = ALUResultIn.
  - If SetSelect[2]=1, ALUResultOut = {15'b0, cond}.
  - cond by SetSelect[1:0]: 00 SEQ=Z; 01 SLT=N; 10 SLE=Z|N; 11 SCO=C.
- Word index = ALUResultIn[ADDR_W:1]. Bit 0 is ignored, so accesses are word-aligned. Bits above ADDR_W are ignored, so addresses alias (wrap) modulo 2^(ADDR_W+1) bytes.
- Store: when DMemEn=1 and DMemWrite=1, mem[index] <= ReadData2 at the rising clk edge.
- Load: when DMemEn=1 and DMemWrite=0, DMemOutData = mem[index], combinationally.
- DMemOutData = 0 whenever DMemEn=0, DMemWrite=1, or rst=0.

## Timing
- Reset: while rst=0, all memory words clear to 0 asynchronously, stores are inhibited, and DMemOutData=0. Pass-through outputs and ALUResultOut remain combinational.
- Reset release takes effect immediately. The first store can occur at the next rising edge with rst=1.
- Store latency is 1 edge. A load of the same word is valid in the cycle after the store edge.
- A store and a load cannot coincide, because DMemWrite selects one or the other.
- Load latency is 0 cycles (combinational from ALUResultIn, DMemEn and DMemWrite).
- ALUResultOut latency is 0 cycles.
- Reset asserted mid-store (before the edge) discards the store.

## Configuration
- MEM_DUMP_EN defined:
  - At a rising edge with DMemDump=1 and rst=1, the simulation prints every nonzero word as index/value.
  - The dump fires once per asserted edge and does not alter memory.
- MEM_DUMP_EN undefined: DMemDump is ignored and no dump logic is compiled.

## Structure
- Shared package holds:
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2;
  - SetSelect encodings SET_EQ=2'b00, SET_LT=2'b01, SET_LE=2'b10, SET_CO=2'b11, and SET_BIT=2.
- One sub-module, data_mem:
  - parameter ADDR_W;
  - asynchronous read, synchronous write, asynchronous active-low clear;
  - contains the optional dump logic.
- The set-condition mux and pass-throughs live in stage_memory.

## Test plan
- Pass-through: SetSelect=3'b011, ALUResultIn=0x0029, DMemEn=0, RegWriteIn=0, MemToRegIn=0, WriteRegIn=3'b011 -> ALUResultOut=0x0029, control outputs equal inputs, DMemOutData=0.
- SEQ: SetSelect=3'b100, ALUFlags=3'b001, ALUResultIn=0x0029 -> ALUResultOut=0x0001. Same with ALUFlags=3'b000 -> 0x0000.
- Other conditions: SetSelect=3'b101 with N=1 -> 1. SetSelect=3'b110 with Z=0, N=0 -> 0. SetSelect=3'b111 with C=1 -> 1.
- Store then load: edge with DMemEn=1, DMemWrite=1, ALUResultIn=0x0032, ReadData2=0x0069. Next cycle DMemWrite=0, ReadData2=0x0123 -> DMemOutData=0x0069.
- Aliasing and disable:
  - Load 0x0033 after the above -> 0x0069 (bit 0 ignored).
  - With ADDR_W=8, load 0x0232 -> 0x0069 (aliases to word 0x19).
  - DMemEn=0 -> 0x0000.
- Reset: after the store, pulse rst low mid-cycle -> load 0x0032 returns 0x0000. A store attempted during reset has no effect.

Source files
------------

// File: rtl/stage_memory_pkg.sv
// Shared definitions for the MEM stage: ALU flag bit positions and set-on-condition encodings.
// Optional feature macro MEM_DUMP_EN lives in data_mem; nothing here depends on it.
package stage_memory_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    localparam int SET_BIT = 2;

    localparam logic [1:0] SET_EQ = 2'b00;
    localparam logic [1:0] SET_LT = 2'b01;
    localparam logic [1:0] SET_LE = 2'b10;
    localparam logic [1:0] SET_CO = 2'b11;

    // Resolves the SEQ/SLT/SLE/SCO condition from the execute-stage flags.
    function automatic logic set_cond(input logic [1:0] sel, input logic [2:0] flags);
        logic cond;
        unique case (sel)
            SET_EQ:  cond = flags[FLAG_Z];
            SET_LT:  cond = flags[FLAG_N];
            SET_LE:  cond = flags[FLAG_Z] | flags[FLAG_N];
            SET_CO:  cond = flags[FLAG_C];
            default: cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/stage_memory_data_mem.sv
// Word-addressed data memory: asynchronous read, synchronous write, asynchronous active-low clear.
// Define MEM_DUMP_EN to print all nonzero words at any clock edge where dump_i is high.
module data_mem
    import stage_memory_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [15:0]       wdata_i,
    input  logic              dump_i,
    output logic [15:0]       rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0] mem_q [DEPTH];
    logic        wr_en_d;

    assign wr_en_d = en_i & we_i;

    // NOTE: the whole array sits on the async clear, so it builds from flops rather than a RAM macro; the pipeline relies on a zeroed memory after every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // NOTE: rdata_o gets its default before any condition so no path leaves it unassigned (no latch).
    always_comb begin
        rdata_o = '0;
        if (rst_n && en_i && !we_i) begin
            rdata_o = mem_q[idx_i];
        end
    end

`ifdef MEM_DUMP_EN
    // Simulation-only; samples the pre-edge contents and never writes memory.
    always @(posedge clk) begin
        if (rst_n && dump_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i] != 16'h0000) begin
                    $display("data_mem dump: index %0d value 0x%04h", i, mem_q[i]);
                end
            end
        end
    end
`else
    logic unused_dump;
    assign unused_dump = dump_i;
`endif

endmodule

// File: rtl/stage_memory.sv
// MEM stage of the 16-bit pipeline: data memory access, set-on-condition resolution, write-back pass-through.
// MEM_DUMP_EN (optional) enables the memory dump inside data_mem.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALUResultIn,
    input  logic [15:0] ReadData2,
    input  logic [2:0]  ALUFlags,
    input  logic [2:0]  SetSelect,
    input  logic        DMemEn,
    input  logic        DMemWrite,
    input  logic        DMemDump,
    input  logic [2:0]  WriteRegIn,
    input  logic        RegWriteIn,
    input  logic        MemToRegIn,
    output logic [2:0]  WriteRegOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut,
    output logic [15:0] ALUResultOut,
    output logic [15:0] DMemOutData
);

    logic [ADDR_W-1:0] word_idx;

    // Byte address to word index: bit 0 dropped, upper bits ignored so addresses alias.
    assign word_idx = ALUResultIn[ADDR_W:1];

    assign WriteRegOut = WriteRegIn;
    assign RegWriteOut = RegWriteIn;
    assign MemToRegOut = MemToRegIn;

    always_comb begin
        ALUResultOut = ALUResultIn;
        if (SetSelect[SET_BIT]) begin
            ALUResultOut = {15'b0, set_cond(SetSelect[1:0], ALUFlags)};
        end
    end

    data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (DMemEn),
        .we_i    (DMemWrite),
        .idx_i   (word_idx),
        .wdata_i (ReadData2),
        .dump_i  (DMemDump),
        .rdata_o (DMemOutData)
    );

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: a scoreboard queue holds predictions made from a bench-side memory model.
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ALUResultIn = '0;
    logic [15:0] ReadData2 = '0;
    logic [2:0]  ALUFlags = '0;
    logic [2:0]  SetSelect = '0;
    logic        DMemEn = 1'b0;
    logic        DMemWrite = 1'b0;
    logic        DMemDump = 1'b0;
    logic [2:0]  WriteRegIn = '0;
    logic        RegWriteIn = 1'b0;
    logic        MemToRegIn = 1'b0;
    logic [2:0]  WriteRegOut;
    logic        RegWriteOut;
    logic        MemToRegOut;
    logic [15:0] ALUResultOut;
    logic [15:0] DMemOutData;

    stage_memory #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALUResultIn  (ALUResultIn),
        .ReadData2    (ReadData2),
        .ALUFlags     (ALUFlags),
        .SetSelect    (SetSelect),
        .DMemEn       (DMemEn),
        .DMemWrite    (DMemWrite),
        .DMemDump     (DMemDump),
        .WriteRegIn   (WriteRegIn),
        .RegWriteIn   (RegWriteIn),
        .MemToRegIn   (MemToRegIn),
        .WriteRegOut  (WriteRegOut),
        .RegWriteOut  (RegWriteOut),
        .MemToRegOut  (MemToRegOut),
        .ALUResultOut (ALUResultOut),
        .DMemOutData  (DMemOutData)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] alu;
        logic [15:0] dout;
        logic [2:0]  wreg;
        logic        rw;
        logic        m2r;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_mem [256];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    endtask

    function automatic logic [15:0] predict_alu(input logic [15:0] a, input logic [2:0] ss,
                                                input logic [2:0] f);
        logic c;
        if (!ss[2]) return a;
        case (ss[1:0])
            2'b00:   c = f[0];
            2'b01:   c = f[1];
            2'b10:   c = f[0] | f[1];
            default: c = f[2];
        endcase
        return {15'h0000, c};
    endfunction

    // Drives one cycle of stimulus at the falling edge, predicts and compares mid-low-phase,
    // then lets the rising edge commit any store into the model.
    task automatic cycle(input string tag, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [2:0] flags, input logic [2:0] ss, input logic en,
                         input logic we, input logic [2:0] wreg, input logic rw, input logic m2r);
        exp_t e;
        logic [7:0] idx;
        @(negedge clk);
        ALUResultIn = addr; ReadData2 = wdata; ALUFlags = flags; SetSelect = ss;
        DMemEn = en; DMemWrite = we; WriteRegIn = wreg; RegWriteIn = rw; MemToRegIn = m2r;
        idx = addr[8:1];
        e.tag  = tag;
        e.alu  = predict_alu(addr, ss, flags);
        e.dout = (rst && en && !we) ? model_mem[idx] : 16'h0000;
        e.wreg = wreg; e.rw = rw; e.m2r = m2r;
        sb_q.push_back(e);
        #2;
        check({tag, ".sb"}, 16'(sb_q.size()), 16'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".alu"}, ALUResultOut, e.alu);
            check({e.tag, ".dout"}, DMemOutData, e.dout);
            check({e.tag, ".ctl"}, {11'h0, WriteRegOut, RegWriteOut, MemToRegOut},
                  {11'h0, e.wreg, e.rw, e.m2r});
        end
        @(posedge clk);
        if (rst && en && we) model_mem[idx] = wdata;
    endtask

    initial begin
        model_clear();
        rst = 1'b0;
        cycle("reset_idle", 16'h0032, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Pass-through and set conditions
        cycle("pass",      16'h0029, 16'h0000, 3'b000, 3'b011, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0);
        cycle("pass_ctl",  16'hBEEF, 16'h0000, 3'b111, 3'b001, 1'b0, 1'b0, 3'b101, 1'b1, 1'b1);
        cycle("seq_z1",    16'h0029, 16'h0000, 3'b001, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("seq_z0",    16'h0029, 16'h0000, 3'b000, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("slt_n1",    16'h0029, 16'h0000, 3'b010, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("slt_n0",    16'h0029, 16'h0000, 3'b101, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("sle_00",    16'h0029, 16'h0000, 3'b000, 3'b110, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("sle_z",     16'h0029, 16'h0000, 3'b001, 3'b110, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("sco_c1",    16'h0029, 16'h0000, 3'b100, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("sco_c0",    16'h0029, 16'h0000, 3'b011, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);

        // Store, load, aliasing, disable
        cycle("store32",   16'h0032, 16'h0069, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle("load32",    16'h0032, 16'h0123, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
        cycle("load33",    16'h0033, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
        cycle("load232",   16'h0232, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
        cycle("load_f032", 16'hF032, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
        cycle("load_dis",  16'h0032, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        cycle("load_wr1",  16'h0034, 16'h5555, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle("load34",    16'h0034, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("store_top", 16'h01FE, 16'hA5A5, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle("load_top",  16'h01FF, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("load_w0",   16'h0000, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);

        // Reset pulse mid-cycle with a store attempted across the edge
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        cycle("rst_store", 16'h0040, 16'hBEEF, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle("rst_load",  16'h0032, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        #2 rst = 1'b1;
        cycle("post_ld32", 16'h0032, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("post_ld40", 16'h0040, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("post_ldtop",16'h01FE, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle("post_st",   16'h0040, 16'h1234, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle("post_ld",   16'h0041, 16'h0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);

        // Randomised mix over a small address window so loads hit stored words
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic        en, we;
            a  = (16'($urandom) & 16'hFE1F);
            en = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) == 0);
            cycle($sformatf("rand%0d", i), a, 16'($urandom), 3'($urandom), 3'($urandom),
                  en, we, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
